// File: rtl/iob_ila_capture_core.sv
// rtl/iob_ila_capture_core.sv - ILA capture engine: circular trace buffer with pre-trigger window
module iob_ila_capture_core #(
    parameter int SIGNAL_W  = 32,
    parameter int TRIGGER_W = 4,
    parameter int BUFFER_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic [SIGNAL_W-1:0]   signal_i,
    input  logic [TRIGGER_W-1:0]  trigger_i,
    input  logic                  sample_en_i,
    input  logic [TRIGGER_W-1:0]  trig_type_i,
    input  logic [TRIGGER_W-1:0]  trig_negate_i,
    input  logic [TRIGGER_W-1:0]  trig_mask_i,
    input  logic                  trig_and_i,
    input  logic [BUFFER_W-1:0]   pretrig_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    output logic [2:0]            state_o,
    output logic                  done_o,
    output logic [BUFFER_W:0]     n_samples_o,
    output logic [BUFFER_W-1:0]   trig_pos_o,
    input  logic                  rd_valid_i,
    input  logic [BUFFER_W-1:0]   rd_index_i,
    output logic [SIGNAL_W-1:0]   rd_data_o,
    output logic                  rd_rvalid_o
);
    localparam int DEPTH = 2 ** BUFFER_W;
    localparam logic [BUFFER_W:0] DEPTH_V = (BUFFER_W+1)'(DEPTH);
    localparam logic [BUFFER_W:0] ONE_V   = (BUFFER_W+1)'(1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]           state;
    logic [TRIGGER_W-1:0] prev_t;
    logic [TRIGGER_W-1:0] cond_t;
    logic [TRIGGER_W-1:0] hit;
    logic [TRIGGER_W-1:0] masked_hit;
    logic                 fire;
    logic [BUFFER_W-1:0]  wptr;
    logic [BUFFER_W-1:0]  pre_cnt;
    logic [BUFFER_W:0]    post_cnt;
    logic [BUFFER_W:0]    post_q;
    logic [BUFFER_W-1:0]  rd_addr;
    logic                 capturing;
    logic                 wr_en;
    logic [SIGNAL_W-1:0]  mem [DEPTH];

    // A BUFFER_W-bit pretrig field can never exceed DEPTH-1, so the clamp is implicit.
    assign pre_cnt    = pretrig_i;
    assign post_q     = DEPTH_V - {1'b0, pre_cnt};

    assign cond_t     = trigger_i ^ trig_negate_i;
    assign hit        = (trig_type_i & cond_t & ~prev_t) | (~trig_type_i & cond_t);
    assign masked_hit = hit & trig_mask_i;
    assign fire       = (trig_mask_i != '0) &&
                        (trig_and_i ? (masked_hit == trig_mask_i) : (masked_hit != '0));

    assign capturing  = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
    // Arm/abort cycles restart or stop the capture and never store a sample.
    assign wr_en      = cke_i && sample_en_i && capturing && !arm_i && !abort_i;
    assign rd_addr    = trig_pos_o - pre_cnt + rd_index_i;
    assign state_o    = state;

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem[wptr] <= signal_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            prev_t      <= '0;
            wptr        <= '0;
            post_cnt    <= '0;
            done_o      <= 1'b0;
            n_samples_o <= '0;
            trig_pos_o  <= '0;
            rd_data_o   <= '0;
            rd_rvalid_o <= 1'b0;
        end else if (cke_i) begin
            prev_t      <= cond_t;
            rd_rvalid_o <= rd_valid_i;
            if (rd_valid_i) begin
                rd_data_o <= mem[rd_addr];
            end

            if (abort_i) begin
                state  <= ST_IDLE;
                done_o <= 1'b0;
            end else if (arm_i) begin
                wptr        <= '0;
                n_samples_o <= '0;
                done_o      <= 1'b0;
                state       <= (pre_cnt == '0) ? ST_WAIT : ST_PRE;
            end else if (wr_en) begin
                wptr <= wptr + 1'b1;
                if (n_samples_o != DEPTH_V) begin
                    n_samples_o <= n_samples_o + ONE_V;
                end
                case (state)
                    ST_PRE: begin
                        if (n_samples_o + ONE_V == {1'b0, pre_cnt}) begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (fire) begin
                            trig_pos_o <= wptr;
                            post_cnt   <= ONE_V;
                            if (post_q == ONE_V) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state  <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post_cnt <= post_cnt + ONE_V;
                        if (post_cnt + ONE_V == post_q) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iob_ila_capture_core.sv
// tb/tb_iob_ila_capture_core.sv - self-checking bench for iob_ila_capture_core
module tb_iob_ila_capture_core;
    localparam int SW = 32;
    localparam int TW = 4;
    localparam int BW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cke = 1'b1;
    logic [SW-1:0] signal = '0;
    logic [TW-1:0] trigger = '0;
    logic          sample_en = 1'b1;
    logic [TW-1:0] trig_type = '0;
    logic [TW-1:0] trig_negate = '0;
    logic [TW-1:0] trig_mask = '0;
    logic          trig_and = 1'b0;
    logic [BW-1:0] pretrig = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    state_o;
    logic          done_o;
    logic [BW:0]   n_samples_o;
    logic [BW-1:0] trig_pos_o;
    logic          rd_valid = 1'b0;
    logic [BW-1:0] rd_index = '0;
    logic [SW-1:0] rd_data_o;
    logic          rd_rvalid_o;

    iob_ila_capture_core #(.SIGNAL_W(SW), .TRIGGER_W(TW), .BUFFER_W(BW)) dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .signal_i(signal), .trigger_i(trigger),
        .sample_en_i(sample_en), .trig_type_i(trig_type), .trig_negate_i(trig_negate),
        .trig_mask_i(trig_mask), .trig_and_i(trig_and), .pretrig_i(pretrig),
        .arm_i(arm), .abort_i(abort), .state_o(state_o), .done_o(done_o),
        .n_samples_o(n_samples_o), .trig_pos_o(trig_pos_o), .rd_valid_i(rd_valid),
        .rd_index_i(rd_index), .rd_data_o(rd_data_o), .rd_rvalid_o(rd_rvalid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the capture is the list of samples written since the last arm.
    logic [SW-1:0] m_hist[$];
    int            m_state = 0;
    int            m_trig_k = 0;
    int            m_post = 0;
    logic          m_done = 1'b0;
    logic [TW-1:0] m_prev = '0;
    logic [BW-1:0] m_trigpos = '0;
    logic          m_rvalid = 1'b0;
    logic [SW-1:0] m_rdata = '0;
    logic          m_data_known = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fire(input logic [TW-1:0] t);
        bit any_hit = 0;
        bit all_hit = 1;
        for (int i = 0; i < TW; i++) begin
            if (trig_mask[i]) begin
                bit h = trig_type[i] ? (t[i] && !m_prev[i]) : t[i];
                any_hit |= h;
                all_hit &= h;
            end
        end
        if (trig_mask == '0) return 0;
        return trig_and ? all_hit : any_hit;
    endfunction

    // Most recent write landing on the physical slot that a logical index maps to.
    function automatic logic [SW-1:0] model_read(input int idx);
        int last = m_hist.size() - 1;
        int ph = (((m_trig_k - int'(pretrig) + idx) % DEPTH) + DEPTH) % DEPTH;
        int j = last - ((((last - ph) % DEPTH) + DEPTH) % DEPTH);
        return m_hist[j];
    endfunction

    task automatic model_update();
        logic [TW-1:0] t;
        bit f;
        int p;
        int q;
        if (rst) begin
            m_state = 0; m_hist.delete(); m_prev = '0; m_done = 0; m_trigpos = '0;
            m_rvalid = 0; m_rdata = '0; m_data_known = 1;
        end else if (cke) begin
            t = trigger ^ trig_negate;
            f = model_fire(t);
            p = int'(pretrig);
            q = DEPTH - p;
            m_rvalid = rd_valid;
            if (rd_valid) begin
                if (m_state == 4) begin
                    m_rdata = model_read(int'(rd_index));
                    m_data_known = 1;
                end else begin
                    m_data_known = 0;
                end
            end
            m_prev = t;
            if (abort) begin
                m_state = 0; m_done = 0;
            end else if (arm) begin
                m_hist.delete(); m_done = 0;
                m_state = (p == 0) ? 2 : 1;
            end else if (m_state >= 1 && m_state <= 3 && sample_en) begin
                m_hist.push_back(signal);
                if (m_state == 1) begin
                    if (m_hist.size() == p) m_state = 2;
                end else if (m_state == 2) begin
                    if (f) begin
                        m_trig_k = m_hist.size() - 1;
                        m_trigpos = BW'(m_trig_k % DEPTH);
                        m_post = 1;
                        if (q == 1) begin m_state = 4; m_done = 1; end
                        else m_state = 3;
                    end
                end else begin
                    m_post++;
                    if (m_post == q) begin m_state = 4; m_done = 1; end
                end
            end
        end
    endtask

    task automatic tick();
        int n;
        @(posedge clk);
        model_update();
        #1;
        n = (m_hist.size() > DEPTH) ? DEPTH : m_hist.size();
        check("state", 64'(state_o), 64'(m_state));
        check("done", 64'(done_o), 64'(m_done));
        check("n_samples", 64'(n_samples_o), 64'(n));
        check("trig_pos", 64'(trig_pos_o), 64'(m_trigpos));
        check("rvalid", 64'(rd_rvalid_o), 64'(m_rvalid));
        if (m_data_known) check("rd_data", 64'(rd_data_o), 64'(m_rdata));
    endtask

    task automatic pulse_arm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic read_idx(input int idx, input logic [SW-1:0] exp);
        rd_valid = 1; rd_index = BW'(idx); tick(); rd_valid = 0;
        check("rd_fixed", 64'(rd_data_o), 64'(exp));
    endtask

    task automatic run_to_done(input int budget);
        int c = 0;
        while (m_state != 4 && c < budget) begin
            signal = $urandom; tick(); c++;
        end
        check("done_within_budget", 64'(done_o), 64'(1));
    endtask

    task automatic level_cfg(input logic [TW-1:0] mask, input logic andm, input int p);
        trig_type = '0; trig_negate = '0; trig_mask = mask; trig_and = andm; pretrig = BW'(p);
    endtask

    initial begin
        tick(); tick();
        check("reset_state", 64'(state_o), 64'(0));
        check("reset_rdata", 64'(rd_data_o), 64'(0));
        rst = 0;

        // Counting capture, trigger on sample 20
        level_cfg(4'b0001, 0, 4);
        pulse_arm();
        for (int c = 0; c < 60 && m_state != 4; c++) begin
            signal = c; trigger = (c == 20) ? 4'b0001 : 4'b0000; tick();
        end
        trigger = '0;
        check("cnt_done", 64'(done_o), 64'(1));
        check("cnt_trigpos", 64'(trig_pos_o), 64'(4));
        check("cnt_n", 64'(n_samples_o), 64'(16));
        read_idx(0, 16);
        read_idx(4, 20);
        read_idx(15, 31);
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1; rd_index = BW'($urandom); tick();
        end
        rd_valid = 0; tick();

        // Rising edge on bit1, then falling edge via negate
        trig_type = 4'b0010; trig_negate = '0; trig_mask = 4'b0010; trig_and = 0; pretrig = 2;
        trigger = 4'b0010;
        pulse_arm();
        for (int i = 0; i < 10; i++) begin signal = $urandom; tick(); end
        check("edge_held_nofire", 64'(state_o), 64'(2));
        trigger = '0; tick();
        check("edge_fall_nofire", 64'(state_o), 64'(2));
        trigger = 4'b0010; tick();
        check("edge_rise_fire", 64'(state_o), 64'(3));
        run_to_done(40);
        trig_negate = 4'b0010; trigger = 4'b0010;
        pulse_arm();
        for (int i = 0; i < 6; i++) tick();
        check("neg_held_nofire", 64'(state_o), 64'(2));
        trigger = '0; tick();
        check("neg_fall_fire", 64'(state_o), 64'(3));
        run_to_done(40);

        // AND mode, and empty mask
        level_cfg(4'b0011, 1, 0);
        trigger = '0;
        pulse_arm();
        check("p0_wait", 64'(state_o), 64'(2));
        trigger = 4'b0001; tick(); tick();
        check("and_partial", 64'(state_o), 64'(2));
        trigger = 4'b0011; tick();
        check("and_full", 64'(state_o), 64'(3));
        run_to_done(40);
        level_cfg(4'b0000, 0, 0);
        pulse_arm();
        for (int i = 0; i < 100; i++) begin trigger = TW'($urandom); tick(); end
        check("mask0_wait", 64'(state_o), 64'(2));
        trig_and = 1;
        for (int i = 0; i < 10; i++) begin trigger = TW'($urandom); tick(); end
        check("mask0_and_wait", 64'(state_o), 64'(2));

        // Qualifier: trigger without sample_en ignored; gaps during POST
        level_cfg(4'b0001, 0, 3);
        trigger = '0; sample_en = 1;
        pulse_arm();
        for (int i = 0; i < 5; i++) begin signal = $urandom; tick(); end
        trigger = 4'b0001; sample_en = 0; tick();
        check("unqualified_trig", 64'(state_o), 64'(2));
        sample_en = 1; tick(); trigger = '0;
        check("qualified_trig", 64'(state_o), 64'(3));
        for (int i = 0; i < 60 && m_state != 4; i++) begin
            sample_en = i[0]; signal = $urandom; tick();
        end
        sample_en = 1;
        check("gap_done", 64'(done_o), 64'(1));
        for (int i = 0; i < 16; i++) begin rd_valid = 1; rd_index = BW'(i); tick(); end
        rd_valid = 0;

        // Largest pretrig: done on the trigger write
        level_cfg(4'b0001, 0, 15);
        pulse_arm();
        for (int i = 0; i < 15; i++) begin signal = $urandom; tick(); end
        check("p15_wait", 64'(state_o), 64'(2));
        trigger = 4'b0001; tick(); trigger = '0;
        check("p15_done", 64'(state_o), 64'(4));
        for (int i = 0; i < 16; i++) begin rd_valid = 1; rd_index = BW'(i); tick(); end
        rd_valid = 0;

        // Abort, arm+abort, reset mid-capture
        level_cfg(4'b0001, 0, 2);
        pulse_arm();
        for (int i = 0; i < 4; i++) tick();
        trigger = 4'b0001; tick(); trigger = '0; tick();
        abort = 1; tick(); abort = 0;
        check("abort_idle", 64'(state_o), 64'(0));
        check("abort_done", 64'(done_o), 64'(0));
        arm = 1; abort = 1; tick(); arm = 0; abort = 0;
        check("arm_abort_idle", 64'(state_o), 64'(0));
        pulse_arm();
        for (int i = 0; i < 6; i++) tick();
        rst = 1; tick(); rst = 0;
        check("rst_state", 64'(state_o), 64'(0));
        check("rst_n", 64'(n_samples_o), 64'(0));
        check("rst_rvalid", 64'(rd_rvalid_o), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            arm = ($urandom_range(0, 39) == 0);
            abort = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 799) == 0);
            cke = ($urandom_range(0, 9) != 0);
            sample_en = ($urandom_range(0, 3) != 0);
            signal = $urandom;
            trigger = ($urandom_range(0, 5) == 0) ? TW'($urandom) : '0;
            rd_valid = $urandom_range(0, 1);
            rd_index = BW'($urandom);
            if (arm) begin
                trig_type = TW'($urandom); trig_negate = TW'($urandom);
                trig_mask = TW'($urandom); trig_and = $urandom_range(0, 1);
                pretrig = BW'($urandom);
            end
            tick();
        end
        arm = 0; abort = 0; rst = 0; cke = 1; rd_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
